// File: rtl/red_pitaya_subsys_seq.sv
`timescale 1ns/1ps
// Purpose: power-sequences N_MOD sub-module enables one bit at a time toward a prefix-closed target.
// Latency: one enable step per SETTLE+1 cycles; done_o is registered on the SETTLE-to-IDLE edge.
// Backpressure: none; req_i/abort_i are level requests, sampled only while IDLE.
//
// Ports:
//   clk, rstn       - rising-edge clock, asynchronous active-low reset
//   req_i[N_MOD]    - requested enable per sub-module (register bank)
//   abort_i         - level force-off; forces the target to all-zero
//   enable_o[N_MOD] - enable per sub-module, always prefix-closed
//   ready_o[N_MOD]  - enabled and no longer settling
//   busy_o          - settling, or enable_o still differs from target
//   done_o          - one-cycle pulse when a settle ends with enable_o at target
module red_pitaya_subsys_seq #(
  parameter int N_MOD  = 4,
  parameter int SETTLE = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_MOD-1:0] req_i,
  input  logic             abort_i,
  output logic [N_MOD-1:0] enable_o,
  output logic [N_MOD-1:0] ready_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int         IW       = (N_MOD > 1) ? $clog2(N_MOD) : 1;
  localparam logic [7:0] CNT_LOAD = 8'(SETTLE - 1);

  typedef enum logic {S_IDLE, S_SETTLE} state_t;

  state_t           state;
  logic [7:0]       cnt;
  logic [IW-1:0]    cur_idx;
  logic [N_MOD-1:0] tgt;
  logic [IW-1:0]    hi_idx;
  logic [IW-1:0]    lo_idx;
  logic             dis_pend;
  logic             en_pend;

  // A sub-module may only be requested if every lower one is, so the
  // target is the running AND of the request bits (abort kills bit 0).
  always_comb begin
    logic run;
    tgt = '0;
    run = ~abort_i;
    for (int k = 0; k < N_MOD; k++) begin
      run    = run & req_i[k];
      tgt[k] = run;
    end
  end

  // enable_o is prefix-closed, so the highest set bit and the lowest
  // clear bit are the only candidates for the next step.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    for (int k = 0; k < N_MOD; k++)
      if (enable_o[k]) hi_idx = IW'(k);
    for (int k = N_MOD - 1; k >= 0; k--)
      if (!enable_o[k]) lo_idx = IW'(k);
  end

  assign dis_pend = |(enable_o & ~tgt);
  assign en_pend  = |(tgt & ~enable_o);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      enable_o <= '0;
      done_o   <= 1'b0;
      cnt      <= 8'd0;
      cur_idx  <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          // Shutting down wins over powering up.
          if (dis_pend) begin
            enable_o[hi_idx] <= 1'b0;
            cur_idx          <= hi_idx;
            cnt              <= CNT_LOAD;
            state            <= S_SETTLE;
          end else if (en_pend) begin
            enable_o[lo_idx] <= 1'b1;
            cur_idx          <= lo_idx;
            cnt              <= CNT_LOAD;
            state            <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          // Request changes here are ignored; the window always runs out.
          if (cnt == 8'd0) begin
            state  <= S_IDLE;
            done_o <= (enable_o == tgt);
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ready_o = '0;
    for (int k = 0; k < N_MOD; k++)
      ready_o[k] = enable_o[k] & ~((state == S_SETTLE) && (cur_idx == IW'(k)));
  end

  assign busy_o = (state == S_SETTLE) | (enable_o != tgt);

endmodule

// File: tb/tb_red_pitaya_subsys_seq.sv
`timescale 1ns/1ps
module tb_red_pitaya_subsys_seq;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] req_i;
  logic       abort_i;
  logic [3:0] enable_o;
  logic [3:0] ready_o;
  logic       busy_o;
  logic       done_o;

  red_pitaya_subsys_seq #(.N_MOD(4), .SETTLE(8)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_i    (req_i),
    .abort_i  (abort_i),
    .enable_o (enable_o),
    .ready_o  (ready_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int total = 0;
  int bad   = 0;

  // Scoreboard: expected enable_o changes (value + cycle) and done_o cycles.
  typedef struct {
    int         cyc;
    logic [3:0] en;
  } ev_t;

  ev_t        ev_q[$];
  int         done_q[$];
  ev_t        ev_m;
  int         dc_m;
  logic [3:0] prev_en = 4'h0;

  task automatic push_ev(input int c, input logic [3:0] e);
    ev_t ev;
    ev.cyc = c;
    ev.en  = e;
    ev_q.push_back(ev);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic to_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (enable_o !== prev_en) begin
      total++;
      if (ev_q.size() == 0) begin
        bad++;
        $error("FAIL enable_unexpected cyc=%0d observed=%h expected=no_change", cyc, enable_o);
      end else begin
        ev_m = ev_q.pop_front();
        assert (enable_o === ev_m.en && cyc == ev_m.cyc) else begin
          bad++;
          $error("FAIL enable_step observed=%h@%0d expected=%h@%0d", enable_o, cyc, ev_m.en, ev_m.cyc);
        end
      end
      prev_en = enable_o;
    end
    if (done_o !== 1'b0) begin
      total++;
      if (done_q.size() == 0) begin
        bad++;
        $error("FAIL done_unexpected cyc=%0d observed=%b expected=0", cyc, done_o);
      end else begin
        dc_m = done_q.pop_front();
        assert (done_o === 1'b1 && cyc == dc_m) else begin
          bad++;
          $error("FAIL done_pulse observed=%b@%0d expected=1@%0d", done_o, cyc, dc_m);
        end
      end
    end
  end

  int c0;

  initial begin
    rstn    = 1'b0;
    req_i   = 4'h0;
    abort_i = 1'b0;

    // Reset state
    to_cyc(2);
    chk("rst_enable", 32'(enable_o), 32'h0);
    chk("rst_done",   32'(done_o),   32'h0);
    chk("rst_ready",  32'(ready_o),  32'h0);
    chk("rst_busy",   32'(busy_o),   32'h0);
    rstn = 1'b1;
    to_cyc(cyc + 2);
    chk("idle_busy", 32'(busy_o), 32'h0);

    // Power-up 0 -> F
    c0 = cyc;
    req_i = 4'hF;
    push_ev(c0 + 1, 4'h1);
    push_ev(c0 + 10, 4'h3);
    push_ev(c0 + 19, 4'h7);
    push_ev(c0 + 28, 4'hF);
    done_q.push_back(c0 + 36);
    to_cyc(c0 + 1);
    chk("pu_ready_settling", 32'(ready_o), 32'h0);
    chk("pu_busy_settling",  32'(busy_o),  32'h1);
    to_cyc(c0 + 9);
    chk("pu_ready_bit0", 32'(ready_o), 32'h1);
    chk("pu_busy_idle",  32'(busy_o),  32'h1);
    to_cyc(c0 + 37);
    chk("pu_ready_all", 32'(ready_o), 32'hF);
    chk("pu_busy_end",  32'(busy_o),  32'h0);
    chk("pu_queue", 32'(ev_q.size() + done_q.size()), 32'h0);

    // Shutdown F -> 0, highest first
    c0 = cyc;
    req_i = 4'h0;
    push_ev(c0 + 1, 4'h7);
    push_ev(c0 + 10, 4'h3);
    push_ev(c0 + 19, 4'h1);
    push_ev(c0 + 28, 4'h0);
    done_q.push_back(c0 + 36);
    to_cyc(c0 + 1);
    chk("sd_ready", 32'(ready_o), 32'h7);
    chk("sd_busy",  32'(busy_o),  32'h1);
    to_cyc(c0 + 38);
    chk("sd_busy_end", 32'(busy_o), 32'h0);
    chk("sd_queue", 32'(ev_q.size() + done_q.size()), 32'h0);

    // Dependency: bit 0 missing, nothing may enable
    c0 = cyc;
    req_i = 4'b1010;
    to_cyc(c0 + 20);
    chk("dep_enable", 32'(enable_o), 32'h0);
    chk("dep_busy",   32'(busy_o),   32'h0);
    req_i = 4'h0;

    // Abort raised 3 cycles after enable_o reaches 3
    c0 = cyc;
    req_i = 4'hF;
    push_ev(c0 + 1, 4'h1);
    push_ev(c0 + 10, 4'h3);
    push_ev(c0 + 19, 4'h1);
    push_ev(c0 + 28, 4'h0);
    done_q.push_back(c0 + 36);
    to_cyc(c0 + 13);
    abort_i = 1'b1;
    #1;
    chk("ab_enable_hold", 32'(enable_o), 32'h3);
    chk("ab_ready",       32'(ready_o),  32'h1);
    chk("ab_busy",        32'(busy_o),   32'h1);
    to_cyc(c0 + 38);
    chk("ab_enable_end", 32'(enable_o), 32'h0);
    chk("ab_busy_end",   32'(busy_o),   32'h0);
    chk("ab_queue", 32'(ev_q.size() + done_q.size()), 32'h0);
    abort_i = 1'b0;
    req_i   = 4'h0;
    to_cyc(cyc + 2);

    // Glitch on req_i[1] inside a settle window
    c0 = cyc;
    req_i = 4'hF;
    push_ev(c0 + 1, 4'h1);
    push_ev(c0 + 10, 4'h3);
    push_ev(c0 + 19, 4'h7);
    push_ev(c0 + 28, 4'hF);
    done_q.push_back(c0 + 36);
    to_cyc(c0 + 12);
    req_i = 4'b1101;
    to_cyc(c0 + 14);
    req_i = 4'hF;
    to_cyc(c0 + 37);
    chk("gl_enable", 32'(enable_o), 32'hF);
    chk("gl_queue", 32'(ev_q.size() + done_q.size()), 32'h0);

    // Async reset mid-settle, then restart with req_i=1
    c0 = cyc;
    req_i = 4'h0;
    push_ev(c0 + 1, 4'h7);
    to_cyc(c0 + 4);
    #2;
    push_ev(c0 + 4, 4'h0);
    rstn = 1'b0;
    #1;
    chk("ar_enable", 32'(enable_o), 32'h0);
    chk("ar_done",   32'(done_o),   32'h0);
    chk("ar_ready",  32'(ready_o),  32'h0);
    chk("ar_busy",   32'(busy_o),   32'h0);
    req_i = 4'h1;
    rstn  = 1'b1;
    push_ev(c0 + 5, 4'h1);
    done_q.push_back(c0 + 13);
    to_cyc(c0 + 15);
    chk("ar_enable_end", 32'(enable_o), 32'h1);
    chk("ar_ready_end",  32'(ready_o),  32'h1);
    chk("ar_busy_end",   32'(busy_o),   32'h0);
    chk("ar_queue", 32'(ev_q.size() + done_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
